stream_fifo: RTL and testbench
==============================

# stream_fifo

Parametrised synchronous FIFO with valid/ready handshakes on both sides, first-word-fall-through output, occupancy count, synchronous flush and optional watermark flags. It is the general-purpose buffer between streaming producers and consumers in the SoC and replaces fixed 32-bit, 8-entry FIFO instances. Storage is a register array of 2**DepthBits entries.

## Interface

- Width, 32, data word width in bits (>= 1)
- DepthBits, 3, log2 of entry count; Depth = 2**DepthBits (>= 1)
- AlmostFullLevel, Depth-1, almost_full asserts when count >= this (1..Depth)
- AlmostEmptyLevel, 1, almost_empty asserts when count <= this (0..Depth-1)

- clk, input, 1, single clock, all state on rising edge
- reset, input, 1, asynchronous, active-high reset
- flush, input, 1, synchronous clear of all contents
- write_valid, input, 1, producer offers write_data
- write_data, input, Width, data to store
- write_ready, output, 1, FIFO can accept a word this cycle
- read_valid, output, 1, read_data holds the oldest word
- read_data, output, Width, oldest stored word (FWFT)
- read_ready, input, 1, consumer takes read_data this cycle
- count, output, DepthBits+1, current occupancy 0..Depth
- almost_full, output, 1, watermark flag (see Configuration)
- almost_empty, output, 1, watermark flag (see Configuration)

## Operation

- Pointers: write and read pointers DepthBits+1 bits; low DepthBits index storage, MSB is wrap bit. Empty = pointers equal; full = low bits equal, MSBs differ. Pointers wrap naturally modulo 2*Depth.
- count = write pointer - read pointer, modulo 2**(DepthBits+1); held in a register updated with the pointers.
- Write accept = write_valid && write_ready; stores write_data at write pointer, increments it.
- Read accept = read_valid && read_ready; increments read pointer.
- write_ready = !full && !reset. Depends only on state, never on read_ready (no ready-to-ready combinational path). When full, a same-cycle read does not raise write_ready that cycle.
- read_valid = !empty; read_data = storage[read pointer low bits]. read_data is don't-care when read_valid is 0; storage is not reset.
- Simultaneous write and read accept when neither empty nor full: both pointers advance, count unchanged.
- write_valid without write_ready: word dropped by producer contract, no state change; read_ready without read_valid: no effect.
- flush: next edge sets both pointers and count to 0. Flush has priority: writes and reads accepted in the flush cycle are discarded.

## Timing

- Reset values (asynchronous, while reset high): pointers 0, count 0, read_valid 0, write_ready 0, almost_full 0, almost_empty 1 (0 if macro absent). write_ready rises on the first clk-independent evaluation after reset falls.
- Write-to-read latency: a word written into an empty FIFO at edge N is visible (read_valid=1) after edge N; consumable at edge N+1. No same-cycle bypass.
- After a read accept at edge N, read_valid/read_data show the next word immediately after edge N.
- Full recovery: after a read accept from full at edge N, write_ready=1 after edge N.
- count, almost_full, almost_empty update after the same edge as pointers.
- Reset mid-transfer: all stored data lost; no accept occurs at an edge where reset is high.

## Configuration

- STREAM_FIFO_WATERMARK_EN defined: almost_full = (count >= AlmostFullLevel), almost_empty = (count <= AlmostEmptyLevel), both registered alongside count.
- Not defined: almost_full and almost_empty tied to 0; threshold parameters unused; no watermark logic synthesised. All other behaviour identical.

## Test plan

- Reset with Width=32, DepthBits=3: reset high -> read_valid=0, write_ready=0, count=0; reset low -> write_ready=1 without a clock edge.
- Fill: 8 writes 0x1..0x8, read_ready=0 -> count=8, write_ready=0 after 8th edge; 9th write 0x9 ignored; drain returns 0x1..0x8 in order, read_valid=0 after last.
- Simultaneous: count=4, write_valid and read_ready held 20 cycles with incrementing data -> count stays 4, order preserved across pointer wrap.
- Full with read: count=8, read_ready=1 and write_valid=1 same cycle -> only read accepted, count=7, write_ready=1 next cycle, write then accepted, count=8.
- Flush: count=5, flush=1 with write_valid=1 and read_ready=1 -> next edge count=0, read_valid=0, no word accepted.
- Watermarks (macro defined, AlmostFullLevel=6, AlmostEmptyLevel=2): count 2 -> almost_empty=1; 3 -> 0; 6 -> almost_full=1; 5 -> 0; macro undefined -> both 0 throughout.

Source files
------------

// File: rtl/stream_fifo_if.sv
`default_nettype none
// ============================================================================
// stream_fifo_if : valid/ready write and read channels, flush and status flags
// Revision: 1.0
// ============================================================================
interface stream_fifo_if #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 3
);
  logic                  flush;
  logic                  write_valid;
  logic [WIDTH-1:0]      write_data;
  logic                  write_ready;
  logic                  read_valid;
  logic [WIDTH-1:0]      read_data;
  logic                  read_ready;
  logic [DEPTH_BITS:0]   count;
  logic                  almost_full;
  logic                  almost_empty;

  modport master (
    output flush, write_valid, write_data, read_ready,
    input  write_ready, read_valid, read_data, count, almost_full, almost_empty
  );

  modport slave (
    input  flush, write_valid, write_data, read_ready,
    output write_ready, read_valid, read_data, count, almost_full, almost_empty
  );
endinterface
`default_nettype wire

// File: rtl/stream_fifo.sv
`default_nettype none
// ============================================================================
// stream_fifo : FWFT valid/ready FIFO with occupancy count and sync flush.
// Watermark flags enabled by defining STREAM_FIFO_WATERMARK_EN.
// Revision: 1.0
// ============================================================================
module stream_fifo #(
  parameter int WIDTH              = 32,
  parameter int DEPTH_BITS         = 3,
  parameter int ALMOST_FULL_LEVEL  = (1 << DEPTH_BITS) - 1,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic         clk,
  input  logic         reset,
  stream_fifo_if.slave bus
);

  localparam int                  c_depth    = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] c_af_level = ALMOST_FULL_LEVEL[DEPTH_BITS:0];
  localparam logic [DEPTH_BITS:0] c_ae_level = ALMOST_EMPTY_LEVEL[DEPTH_BITS:0];

  logic [WIDTH-1:0]    r_mem [c_depth];
  logic [DEPTH_BITS:0] r_wr_ptr;
  logic [DEPTH_BITS:0] r_rd_ptr;
  logic [DEPTH_BITS:0] r_count;

  logic                w_full;
  logic                w_empty;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [DEPTH_BITS:0] w_wr_ptr_d;
  logic [DEPTH_BITS:0] w_rd_ptr_d;
  logic [DEPTH_BITS:0] w_count_d;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[DEPTH_BITS-1:0] == r_rd_ptr[DEPTH_BITS-1:0]) &&
                   (r_wr_ptr[DEPTH_BITS] != r_rd_ptr[DEPTH_BITS]);

  // write_ready depends on state and reset only, never on read_ready
  assign bus.write_ready = !w_full && !reset;
  assign bus.read_valid  = !w_empty;
  assign bus.read_data   = r_mem[r_rd_ptr[DEPTH_BITS-1:0]];
  assign bus.count       = r_count;

  assign w_wr_acc = bus.write_valid && bus.write_ready;
  assign w_rd_acc = bus.read_valid && bus.read_ready;

  // Flush overrides any accept in the same cycle
  always_comb begin
    w_wr_ptr_d = r_wr_ptr + {{DEPTH_BITS{1'b0}}, w_wr_acc};
    w_rd_ptr_d = r_rd_ptr + {{DEPTH_BITS{1'b0}}, w_rd_acc};
    if (bus.flush) begin
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
    end
    w_count_d = w_wr_ptr_d - w_rd_ptr_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc && !bus.flush) begin
      r_mem[r_wr_ptr[DEPTH_BITS-1:0]] <= bus.write_data;
    end
  end

`ifdef STREAM_FIFO_WATERMARK_EN
  logic r_almost_full;
  logic r_almost_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_full  <= (w_count_d >= c_af_level);
      r_almost_empty <= (w_count_d <= c_ae_level);
    end
  end

  assign bus.almost_full  = r_almost_full;
  assign bus.almost_empty = r_almost_empty;
`else
  logic w_unused_levels;
  assign w_unused_levels  = ^{c_af_level, c_ae_level};
  assign bus.almost_full  = 1'b0;
  assign bus.almost_empty = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo.sv
`default_nettype none
// ============================================================================
// tb_stream_fifo : directed self-checking bench for stream_fifo (32 x 8)
// Revision: 1.0
// ============================================================================
module tb_stream_fifo;

  localparam int c_width      = 32;
  localparam int c_depth_bits = 3;
  localparam int c_af_level   = 6;
  localparam int c_ae_level   = 2;
`ifdef STREAM_FIFO_WATERMARK_EN
  localparam bit c_wm = 1'b1;
`else
  localparam bit c_wm = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  stream_fifo_if #(.WIDTH(c_width), .DEPTH_BITS(c_depth_bits)) bus ();

  stream_fifo #(
    .WIDTH             (c_width),
    .DEPTH_BITS        (c_depth_bits),
    .ALMOST_FULL_LEVEL (c_af_level),
    .ALMOST_EMPTY_LEVEL(c_ae_level)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int cnt);
    check({tag, " count"},        32'(bus.count),        32'(cnt));
    check({tag, " read_valid"},   32'(bus.read_valid),   32'(cnt != 0));
    check({tag, " write_ready"},  32'(bus.write_ready),  32'(cnt != 8));
    check({tag, " almost_full"},  32'(bus.almost_full),  32'(c_wm && cnt >= 6));
    check({tag, " almost_empty"}, 32'(bus.almost_empty), 32'(c_wm && cnt <= 2));
  endtask

  task automatic push(input logic [31:0] d);
    bus.write_valid = 1'b1;
    bus.write_data  = d;
    step();
    bus.write_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    check({tag, " read_data"}, bus.read_data, exp);
    bus.read_ready = 1'b1;
    step();
    bus.read_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    bus.flush       = 1'b0;
    bus.write_valid = 1'b0;
    bus.write_data  = '0;
    bus.read_ready  = 1'b0;

    // Reset state, then write_ready rises without a clock edge
    #2;
    check("reset count",        32'(bus.count),        32'd0);
    check("reset read_valid",   32'(bus.read_valid),   32'd0);
    check("reset write_ready",  32'(bus.write_ready),  32'd0);
    check("reset almost_full",  32'(bus.almost_full),  32'd0);
    check("reset almost_empty", 32'(bus.almost_empty), 32'(c_wm));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("post-reset write_ready", 32'(bus.write_ready), 32'd1);

    // Fill to full, overfill is ignored, drain in order
    for (int i = 1; i <= 8; i++) begin
      push(32'(i));
      check_state($sformatf("fill%0d", i), i);
    end
    check("full head", bus.read_data, 32'd1);
    push(32'd9);
    check_state("overfill", 8);
    for (int i = 1; i <= 8; i++) begin
      pop_check($sformatf("drain%0d", i), 32'(i));
      check_state($sformatf("drain%0d", i), 8 - i);
    end

    // Concurrent write and read at count 4 across pointer wrap
    for (int i = 0; i < 4; i++) push(32'(100 + i));
    check_state("sim start", 4);
    bus.write_valid = 1'b1;
    bus.read_ready  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.write_data = 32'(104 + k);
      check($sformatf("sim%0d read_data", k), bus.read_data, 32'(100 + k));
      step();
      check($sformatf("sim%0d count", k), 32'(bus.count), 32'd4);
    end
    bus.write_valid = 1'b0;
    bus.read_ready  = 1'b0;
    for (int i = 0; i < 4; i++) pop_check($sformatf("sim tail%0d", i), 32'(120 + i));
    check_state("sim end", 0);

    // Full with simultaneous read: only the read is accepted
    for (int i = 0; i < 8; i++) push(32'(200 + i));
    check_state("fr full", 8);
    bus.write_valid = 1'b1;
    bus.write_data  = 32'h300;
    bus.read_ready  = 1'b1;
    check("fr write_ready before", 32'(bus.write_ready), 32'd0);
    step();
    bus.read_ready = 1'b0;
    check_state("fr after read", 7);
    check("fr head", bus.read_data, 32'd201);
    step();
    bus.write_valid = 1'b0;
    check_state("fr refill", 8);
    for (int i = 1; i < 8; i++) pop_check($sformatf("fr drain%0d", i), 32'(200 + i));
    pop_check("fr drain last", 32'h300);
    check_state("fr empty", 0);

    // Flush discards contents and any same-cycle accept
    for (int i = 0; i < 5; i++) push(32'(400 + i));
    check_state("fl pre", 5);
    bus.flush       = 1'b1;
    bus.write_valid = 1'b1;
    bus.write_data  = 32'h500;
    bus.read_ready  = 1'b1;
    step();
    bus.flush       = 1'b0;
    bus.write_valid = 1'b0;
    bus.read_ready  = 1'b0;
    check_state("fl post", 0);
    step();
    check_state("fl idle", 0);
    push(32'h600);
    check_state("fl reuse", 1);
    pop_check("fl reuse", 32'h600);
    check_state("fl reuse end", 0);

    // Asynchronous reset mid-transfer loses all data
    for (int i = 0; i < 3; i++) push(32'(32'h700 + i));
    #2;
    reset = 1'b1;
    #1;
    check("mid-reset count",       32'(bus.count),       32'd0);
    check("mid-reset read_valid",  32'(bus.read_valid),  32'd0);
    check("mid-reset write_ready", 32'(bus.write_ready), 32'd0);
    bus.write_valid = 1'b1;
    bus.write_data  = 32'h7ff;
    step();
    check("reset-edge count", 32'(bus.count), 32'd0);
    reset           = 1'b0;
    bus.write_valid = 1'b0;
    #1;
    check_state("after reset", 0);
    push(32'h7a5);
    check_state("after reset push", 1);
    pop_check("after reset", 32'h7a5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
